i2c_pointer_responder: RTL and testbench
========================================

Name: i2c_pointer_responder

Overview:
- I2C target-side responder for the pointer-write transaction issued by the team's I2C pointer-write initiator.
- Oversamples SCL/SDA on its own clock and detects START, STOP and repeated START.
- Shifts in the 8-bit address byte and ACKs it on a match, then shifts in the pointer byte, ACKs it and presents it with a one-cycle valid strobe.
- Used in simulation benches and FPGA loopback builds as the device model behind the camera/sensor I2C path.

Parameters:
- SLAVE_ADDRESS, 8'h6C, full 8-bit write address byte; LSB must be 0; received byte must equal it exactly.
- FILTER_LEN, 2, PT_CK cycles a synchronized line must hold a new level before it is accepted (glitch filter, 1..7).

Ports:
- PT_CK  input  1  responder clock; must be >= 8x the SCL toggle rate.
- RESET_N  input  1  synchronous active-low reset.
- SCLI  input  1  raw SCL line level.
- SDAI  input  1  raw SDA line level.
- HOLD  input  1  1 = NACK own address (emulates a sleeping device for wake polling).
- SDAO  output  1  0 = pull SDA low, 1 = release.
- POINTER  output  8  last accepted pointer byte.
- PTR_VALID  output  1  one-cycle pulse when POINTER updates.
- ADDR_HIT  output  1  one-cycle pulse when the address is ACKed.
- ST  output  4  current state (test).
- BIT_CNT  output  4  bits received in the current byte, 0..9 (test).

Behaviour:
- Clock and reset
  - Single clock, PT_CK. Reset is synchronous and active-low on RESET_N.
  - Reset values: SDAO=1, POINTER=0, PTR_VALID=0, ADDR_HIT=0, ST=IDLE(0), BIT_CNT=0, shift register 0.
  - Synchronizers and filters reset to 1 (lines idle high).
- Input conditioning
  - Each line passes through a 2-flop synchronizer, then the FILTER_LEN stable-count filter, giving scl_f and sda_f.
  - Edge detect on the filtered signals only.
- Bus conditions
  - START = sda_f falls while scl_f high.
  - STOP = sda_f rises while scl_f high.
  - Data bits are sampled on scl_f rising edges.
  - SDAO changes only on scl_f falling edges, one cycle after detection.
- States: IDLE(0), ADDR(1), ADDR_ACK(2), PTR(3), PTR_ACK(4), DATA(5), DATA_ACK(6), WAIT_STOP(7).
  - IDLE: SDAO=1. START -> ADDR, BIT_CNT=0.
  - ADDR: shift MSB first on each SCL rise; BIT_CNT++.
    - At the SCL fall after bit 8: if byte==SLAVE_ADDRESS and HOLD==0, drive SDAO=0, pulse ADDR_HIT, go to ADDR_ACK.
    - Otherwise keep SDAO=1 and go to WAIT_STOP.
  - ADDR_ACK: the 9th SCL rise counts as the ack bit (BIT_CNT=9). At the following SCL fall: SDAO=1, BIT_CNT=0, go to PTR.
  - PTR: 8 bits as in ADDR. At the SCL fall after bit 8: SDAO=0, POINTER<=byte, pulse PTR_VALID, go to PTR_ACK.
  - PTR_ACK: at the SCL fall after the 9th rise: SDAO=1.
    - With the optional feature compiled in: go to DATA.
    - Without it: go to WAIT_STOP.
  - WAIT_STOP: SDAO=1; ignore SCL activity.
- Global transitions and edge cases
  - STOP in any state: go to IDLE, SDAO=1 in the same cycle, BIT_CNT=0; no pulses.
  - START (repeated) in any non-IDLE state: go to ADDR, SDAO=1, BIT_CNT=0. A partial byte is discarded; POINTER is unchanged.
  - Address-only transaction (START, address, ACK, STOP) is legal: ADDR_HIT pulses, PTR_VALID does not.
  - A STOP during the PTR byte leaves POINTER unchanged.
  - HOLD is sampled at the address-ack decision point only.
  - Read address (byte LSB=1) never matches: NACK.
  - SDAO is never driven low while scl_f is high, except to hold an ACK through its high phase.

Optional Feature:
- Macro: I2C_RESP_DATA_EN.
- Defined:
  - Adds output DATA[7:0] (reset 0) and output DATA_VALID (1-cycle pulse).
  - DATA state receives a byte, ACKs it, sets DATA<=byte and pulses DATA_VALID, then POINTER<=POINTER+1 (wraps 8'hFF->8'h00, no PTR_VALID pulse). Goes to DATA_ACK.
  - DATA_ACK releases SDAO and returns to DATA.
  - Repeats until STOP or START.
- Undefined: bytes after the pointer byte are NACKed (WAIT_STOP), and the ports DATA and DATA_VALID do not exist.

Test Plan:
1. Reset with RESET_N=0 for 3 cycles while SCL/SDA toggle -> SDAO=1, POINTER=0, ST=0, no pulses.
2. Write 8'h6C then 8'h0A, then STOP -> SDAO=0 during both ack bits, ADDR_HIT then PTR_VALID each 1 cycle, POINTER=8'h0A, ST=0 after STOP.
3. Address 8'h6E -> SDA stays high at the ack bit, ST=7, POINTER unchanged, no pulses.
4. HOLD=1 with address 8'h6C, STOP, then HOLD=0 and a retry with 8'h6C -> first attempt NACK, retry ACK; address-only retry gives ADDR_HIT, no PTR_VALID.
5. Address 8'h6C, 4 bits of pointer, repeated START, address 8'h6C, pointer 8'h33 -> POINTER=8'h33, single PTR_VALID.
6. With I2C_RESP_DATA_EN defined: pointer 8'hFF, data 8'h11 and 8'h22 -> two DATA_VALID pulses, DATA=8'h22, POINTER=8'h01, all bytes ACKed.
   - Without the macro, the same stimulus -> the first data byte is NACKed.

Source files
------------

// File: rtl/i2c_pointer_responder.sv
// rtl/i2c_pointer_responder.sv - I2C target responder for pointer-write transactions
//
// Purpose: oversamples SCL/SDA on PT_CK, detects START/STOP/repeated START,
// ACKs a matching write address, captures the following pointer byte and
// strobes it out. Optional data-byte reception with auto-increment of the
// pointer is compiled in with the I2C_RESP_DATA_EN macro.
//
// Ports:
//   PT_CK       responder clock (>= 8x SCL toggle rate)
//   RESET_N     synchronous active-low reset
//   SCLI, SDAI  raw bus line levels
//   HOLD        1 = NACK own address (sleeping device emulation)
//   SDAO        0 = pull SDA low, 1 = release
//   POINTER     last accepted pointer byte
//   PTR_VALID   one-cycle pulse when POINTER is loaded from the bus
//   ADDR_HIT    one-cycle pulse when the address is ACKed
//   ST          current state (test)
//   BIT_CNT     bits received in the current byte, 0..9 (test)
//   DATA, DATA_VALID  last data byte and its strobe (I2C_RESP_DATA_EN only)

module i2c_pointer_responder #(
  parameter logic [7:0]  SLAVE_ADDRESS = 8'h6C,
  parameter int unsigned FILTER_LEN    = 2
) (
  input  logic       PT_CK,
  input  logic       RESET_N,
  input  logic       SCLI,
  input  logic       SDAI,
  input  logic       HOLD,
  output logic       SDAO,
  output logic [7:0] POINTER,
  output logic       PTR_VALID,
  output logic       ADDR_HIT,
  output logic [3:0] ST,
  output logic [3:0] BIT_CNT
`ifdef I2C_RESP_DATA_EN
  ,
  output logic [7:0] DATA,
  output logic       DATA_VALID
`endif
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    DATA_ST   = 4'd5,
    DATA_ACK  = 4'd6,
    WAIT_STOP = 4'd7
  } state_t;

  localparam logic [2:0] FILT_MAX = 3'(FILTER_LEN - 1);

  // Input conditioning: 2-flop synchronizer, stable-count filter, edge history
  logic       scl_meta_q, scl_sync_q, scl_f_q, scl_prev_q;
  logic       sda_meta_q, sda_sync_q, sda_f_q, sda_prev_q;
  logic [2:0] scl_cnt_q, sda_cnt_q;
  logic       scl_f_d, sda_f_d;
  logic [2:0] scl_cnt_d, sda_cnt_d;

  // Protocol state
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] pointer_q, pointer_d;
  logic       sdao_q, sdao_d;
  logic       ptr_valid_q, ptr_valid_d;
  logic       addr_hit_q, addr_hit_d;
`ifdef I2C_RESP_DATA_EN
  logic [7:0] data_q, data_d;
  logic       data_valid_q, data_valid_d;
`endif

  logic scl_rise, scl_fall, start_det, stop_det;

  // A new level must persist for FILTER_LEN consecutive cycles to be accepted.
  always_comb begin
    scl_f_d   = scl_f_q;
    scl_cnt_d = 3'd0;
    if (scl_sync_q != scl_f_q) begin
      if (scl_cnt_q == FILT_MAX) scl_f_d = scl_sync_q;
      else                       scl_cnt_d = scl_cnt_q + 3'd1;
    end
    sda_f_d   = sda_f_q;
    sda_cnt_d = 3'd0;
    if (sda_sync_q != sda_f_q) begin
      if (sda_cnt_q == FILT_MAX) sda_f_d = sda_sync_q;
      else                       sda_cnt_d = sda_cnt_q + 3'd1;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q & scl_prev_q;
  // SCL must be high on both sides of the SDA edge to count as a condition
  assign start_det = sda_prev_q & ~sda_f_q & scl_f_q & scl_prev_q;
  assign stop_det  = ~sda_prev_q & sda_f_q & scl_f_q & scl_prev_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pointer_d   = pointer_q;
    sdao_d      = sdao_q;
    ptr_valid_d = 1'b0;
    addr_hit_d  = 1'b0;
`ifdef I2C_RESP_DATA_EN
    data_d       = data_q;
    data_valid_d = 1'b0;
`endif
    if (stop_det) begin
      state_d   = IDLE;
      sdao_d    = 1'b1;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      // Repeated START discards any partial byte; POINTER is left alone.
      state_d   = ADDR;
      sdao_d    = 1'b1;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ADDR, PTR, DATA_ST: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            case (state_q)
              ADDR: begin
                if (shift_q == SLAVE_ADDRESS && !HOLD) begin
                  sdao_d     = 1'b0;
                  addr_hit_d = 1'b1;
                  state_d    = ADDR_ACK;
                end else begin
                  sdao_d  = 1'b1;
                  state_d = WAIT_STOP;
                end
              end
              PTR: begin
                sdao_d      = 1'b0;
                pointer_d   = shift_q;
                ptr_valid_d = 1'b1;
                state_d     = PTR_ACK;
              end
              default: begin
`ifdef I2C_RESP_DATA_EN
                sdao_d       = 1'b0;
                data_d       = shift_q;
                data_valid_d = 1'b1;
                pointer_d    = pointer_q + 8'd1;
                state_d      = DATA_ACK;
`else
                state_d = WAIT_STOP;
`endif
              end
            endcase
          end
        end
        ADDR_ACK, PTR_ACK, DATA_ACK: begin
          // The ACK is held low through the 9th SCL high phase and released
          // on the fall that ends it.
          if (scl_rise) begin
            bit_cnt_d = 4'd9;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            sdao_d    = 1'b1;
            bit_cnt_d = 4'd0;
            case (state_q)
              ADDR_ACK: state_d = PTR;
`ifdef I2C_RESP_DATA_EN
              default:  state_d = DATA_ST;
`else
              default:  state_d = WAIT_STOP;
`endif
            endcase
          end
        end
        default: sdao_d = 1'b1;  // IDLE, WAIT_STOP
      endcase
    end
  end

  always_ff @(posedge PT_CK) begin
    if (!RESET_N) begin
      scl_meta_q  <= 1'b1;
      scl_sync_q  <= 1'b1;
      scl_f_q     <= 1'b1;
      scl_prev_q  <= 1'b1;
      scl_cnt_q   <= 3'd0;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
      sda_f_q     <= 1'b1;
      sda_prev_q  <= 1'b1;
      sda_cnt_q   <= 3'd0;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      pointer_q   <= 8'd0;
      sdao_q      <= 1'b1;
      ptr_valid_q <= 1'b0;
      addr_hit_q  <= 1'b0;
`ifdef I2C_RESP_DATA_EN
      data_q       <= 8'd0;
      data_valid_q <= 1'b0;
`endif
    end else begin
      scl_meta_q  <= SCLI;
      scl_sync_q  <= scl_meta_q;
      scl_f_q     <= scl_f_d;
      scl_prev_q  <= scl_f_q;
      scl_cnt_q   <= scl_cnt_d;
      sda_meta_q  <= SDAI;
      sda_sync_q  <= sda_meta_q;
      sda_f_q     <= sda_f_d;
      sda_prev_q  <= sda_f_q;
      sda_cnt_q   <= sda_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pointer_q   <= pointer_d;
      sdao_q      <= sdao_d;
      ptr_valid_q <= ptr_valid_d;
      addr_hit_q  <= addr_hit_d;
`ifdef I2C_RESP_DATA_EN
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
`endif
    end
  end

  assign SDAO      = sdao_q;
  assign POINTER   = pointer_q;
  assign PTR_VALID = ptr_valid_q;
  assign ADDR_HIT  = addr_hit_q;
  assign ST        = state_q;
  assign BIT_CNT   = bit_cnt_q;
`ifdef I2C_RESP_DATA_EN
  assign DATA       = data_q;
  assign DATA_VALID = data_valid_q;
`endif

endmodule

// File: tb/tb_i2c_pointer_responder.sv
// tb/tb_i2c_pointer_responder.sv - directed self-checking bench for i2c_pointer_responder

module tb_i2c_pointer_responder;

  localparam int Q = 10;  // PT_CK cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       hold = 1'b0;
  logic       sdao;
  logic       sda_line;
  logic [7:0] pointer;
  logic       ptr_valid, addr_hit;
  logic [3:0] st, bit_cnt;
`ifdef I2C_RESP_DATA_EN
  logic [7:0] data;
  logic       data_valid;
`endif

  int checks = 0;
  int errors = 0;
  int addr_hit_n = 0;
  int ptr_valid_n = 0;
  int data_valid_n = 0;

  assign sda_line = sda_m & sdao;  // open-drain wired-AND bus

  always #5 clk = ~clk;

  i2c_pointer_responder #(.SLAVE_ADDRESS(8'h6C), .FILTER_LEN(2)) dut (
    .PT_CK     (clk),
    .RESET_N   (rst_n),
    .SCLI      (scl_m),
    .SDAI      (sda_line),
    .HOLD      (hold),
    .SDAO      (sdao),
    .POINTER   (pointer),
    .PTR_VALID (ptr_valid),
    .ADDR_HIT  (addr_hit),
    .ST        (st),
    .BIT_CNT   (bit_cnt)
`ifdef I2C_RESP_DATA_EN
    ,
    .DATA      (data),
    .DATA_VALID(data_valid)
`endif
  );

  // Count high cycles of each strobe; a clean single pulse adds exactly 1.
  always @(negedge clk) begin
    if (addr_hit)  addr_hit_n  <= addr_hit_n + 1;
    if (ptr_valid) ptr_valid_n <= ptr_valid_n + 1;
`ifdef I2C_RESP_DATA_EN
    if (data_valid) data_valid_n <= data_valid_n + 1;
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = sda_line;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scl_m = ~scl_m; sda_m = ~sda_m; tick(1);
    end
    checks++; if (sdao !== 1'b1) begin errors++; $display("FAIL reset_sdao got %b exp 1", sdao); end
    checks++; if (pointer !== 8'h00) begin errors++; $display("FAIL reset_pointer got %h exp 00", pointer); end
    checks++; if (st !== 4'd0) begin errors++; $display("FAIL reset_st got %0d exp 0", st); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d exp 0", bit_cnt); end
    scl_m = 1'b1; sda_m = 1'b1; tick(2);
    rst_n = 1'b1; tick(10);
    checks++; if (st !== 4'd0 || sdao !== 1'b1) begin errors++; $display("FAIL post_reset_idle got st=%0d sdao=%b exp st=0 sdao=1", st, sdao); end
    checks++; if (addr_hit_n !== 0 || ptr_valid_n !== 0) begin errors++; $display("FAIL reset_pulses got hit=%0d pv=%0d exp 0 0", addr_hit_n, ptr_valid_n); end
  endtask

  task automatic test_write_pointer();
    int h0, p0;
    logic a1, a2;
    h0 = addr_hit_n; p0 = ptr_valid_n;
    bus_start();
    checks++; if (st !== 4'd1) begin errors++; $display("FAIL wp_st_addr got %0d exp 1", st); end
    send_byte(8'h6C, a1);
    send_byte(8'h0A, a2);
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL wp_addr_ack got %b exp 0", a1); end
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL wp_ptr_ack got %b exp 0", a2); end
`ifdef I2C_RESP_DATA_EN
    checks++; if (st !== 4'd5) begin errors++; $display("FAIL wp_st_after_ptr got %0d exp 5", st); end
`else
    checks++; if (st !== 4'd7) begin errors++; $display("FAIL wp_st_after_ptr got %0d exp 7", st); end
`endif
    bus_stop();
    checks++; if (addr_hit_n - h0 !== 1) begin errors++; $display("FAIL wp_addr_hit got %0d exp 1", addr_hit_n - h0); end
    checks++; if (ptr_valid_n - p0 !== 1) begin errors++; $display("FAIL wp_ptr_valid got %0d exp 1", ptr_valid_n - p0); end
    checks++; if (pointer !== 8'h0A) begin errors++; $display("FAIL wp_pointer got %h exp 0a", pointer); end
    checks++; if (st !== 4'd0) begin errors++; $display("FAIL wp_st_stop got %0d exp 0", st); end
  endtask

  task automatic test_wrong_address();
    int h0, p0;
    logic a1;
    h0 = addr_hit_n; p0 = ptr_valid_n;
    bus_start();
    send_byte(8'h6E, a1);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL wa_nack got %b exp 1", a1); end
    checks++; if (st !== 4'd7) begin errors++; $display("FAIL wa_st got %0d exp 7", st); end
    bus_stop();
    checks++; if (pointer !== 8'h0A) begin errors++; $display("FAIL wa_pointer got %h exp 0a", pointer); end
    checks++; if (addr_hit_n - h0 !== 0 || ptr_valid_n - p0 !== 0) begin errors++; $display("FAIL wa_pulses got hit=%0d pv=%0d exp 0 0", addr_hit_n - h0, ptr_valid_n - p0); end
    checks++; if (st !== 4'd0) begin errors++; $display("FAIL wa_st_stop got %0d exp 0", st); end
  endtask

  task automatic test_hold_retry();
    int h0, p0;
    logic a1, a2;
    h0 = addr_hit_n; p0 = ptr_valid_n;
    hold = 1'b1;
    bus_start();
    send_byte(8'h6C, a1);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL hold_nack got %b exp 1", a1); end
    checks++; if (st !== 4'd7) begin errors++; $display("FAIL hold_st got %0d exp 7", st); end
    bus_stop();
    hold = 1'b0;
    bus_start();
    send_byte(8'h6C, a2);
    bus_stop();
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL retry_ack got %b exp 0", a2); end
    checks++; if (addr_hit_n - h0 !== 1) begin errors++; $display("FAIL retry_addr_hit got %0d exp 1", addr_hit_n - h0); end
    checks++; if (ptr_valid_n - p0 !== 0) begin errors++; $display("FAIL retry_ptr_valid got %0d exp 0", ptr_valid_n - p0); end
    checks++; if (pointer !== 8'h0A || st !== 4'd0) begin errors++; $display("FAIL retry_state got ptr=%h st=%0d exp 0a 0", pointer, st); end
  endtask

  task automatic test_repeated_start();
    int h0, p0;
    logic a1, a2, a3;
    h0 = addr_hit_n; p0 = ptr_valid_n;
    bus_start();
    send_byte(8'h6C, a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    checks++; if (st !== 4'd3 || bit_cnt !== 4'd4) begin errors++; $display("FAIL rs_partial got st=%0d bits=%0d exp 3 4", st, bit_cnt); end
    bus_start();
    checks++; if (st !== 4'd1 || bit_cnt !== 4'd0) begin errors++; $display("FAIL rs_restart got st=%0d bits=%0d exp 1 0", st, bit_cnt); end
    checks++; if (pointer !== 8'h0A) begin errors++; $display("FAIL rs_ptr_kept got %h exp 0a", pointer); end
    send_byte(8'h6C, a2);
    send_byte(8'h33, a3);
    bus_stop();
    checks++; if ({a1, a2, a3} !== 3'b000) begin errors++; $display("FAIL rs_acks got %b exp 000", {a1, a2, a3}); end
    checks++; if (pointer !== 8'h33) begin errors++; $display("FAIL rs_pointer got %h exp 33", pointer); end
    checks++; if (ptr_valid_n - p0 !== 1) begin errors++; $display("FAIL rs_ptr_valid got %0d exp 1", ptr_valid_n - p0); end
    checks++; if (addr_hit_n - h0 !== 2) begin errors++; $display("FAIL rs_addr_hit got %0d exp 2", addr_hit_n - h0); end
  endtask

  task automatic test_data_bytes();
    int p0, d0;
    logic a1, a2, a3, a4;
    p0 = ptr_valid_n; d0 = data_valid_n;
    bus_start();
    send_byte(8'h6C, a1);
    send_byte(8'hFF, a2);
    send_byte(8'h11, a3);
    send_byte(8'h22, a4);
`ifndef I2C_RESP_DATA_EN
    checks++; if (st !== 4'd7) begin errors++; $display("FAIL db_st got %0d exp 7", st); end
`endif
    bus_stop();
    checks++; if ({a1, a2} !== 2'b00) begin errors++; $display("FAIL db_hdr_acks got %b exp 00", {a1, a2}); end
    checks++; if (ptr_valid_n - p0 !== 1) begin errors++; $display("FAIL db_ptr_valid got %0d exp 1", ptr_valid_n - p0); end
`ifdef I2C_RESP_DATA_EN
    checks++; if ({a3, a4} !== 2'b00) begin errors++; $display("FAIL db_data_acks got %b exp 00", {a3, a4}); end
    checks++; if (data_valid_n - d0 !== 2) begin errors++; $display("FAIL db_data_valid got %0d exp 2", data_valid_n - d0); end
    checks++; if (data !== 8'h22) begin errors++; $display("FAIL db_data got %h exp 22", data); end
    checks++; if (pointer !== 8'h01) begin errors++; $display("FAIL db_pointer got %h exp 01", pointer); end
`else
    checks++; if (a3 !== 1'b1) begin errors++; $display("FAIL db_data_nack got %b exp 1", a3); end
    checks++; if (data_valid_n - d0 !== 0) begin errors++; $display("FAIL db_data_valid got %0d exp 0", data_valid_n - d0); end
    checks++; if (pointer !== 8'hFF) begin errors++; $display("FAIL db_pointer got %h exp ff", pointer); end
`endif
    checks++; if (st !== 4'd0 || sdao !== 1'b1) begin errors++; $display("FAIL db_idle got st=%0d sdao=%b exp 0 1", st, sdao); end
  endtask

  initial begin
    test_reset();
    test_write_pointer();
    test_wrong_address();
    test_hold_retry();
    test_repeated_start();
    test_data_bytes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
